// File: rtl/ucie_ctl_rx_pkg.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_pkg
// Shared definitions for the UCIe controller RX flit assembler slice.
//   DEF_NBYTES / DEF_BEATS : default beat width (bits) and beats per flit
//   FLIT_W                 : assembled flit width for the defaults
//   CNT_W                  : beat counter width for the defaults
//   fill_state_e           : per-flit fill state machine encoding
// ---------------------------------------------------------------------------
package ucie_ctl_rx_pkg;

  localparam int DEF_NBYTES = 32;
  localparam int DEF_BEATS  = 4;
  localparam int FLIT_W     = DEF_NBYTES * DEF_BEATS;
  localparam int CNT_W      = $clog2(DEF_BEATS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage : ucie_ctl_rx_pkg

// File: rtl/ucie_ctl_rx_flit_bank.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_flit_bank
// One flit storage bank: a beat-slice write port plus a full flag.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_wr_en           write i_wr_data into slice i_wr_slot
//   i_wr_slot         beat index within the flit
//   i_wr_data         beat payload
//   i_set_full        mark the bank full (last beat of a flit)
//   i_clr_full        release the bank (flit popped by the consumer)
//   o_data            registered flit contents
//   o_full            registered full flag
// ---------------------------------------------------------------------------
module ucie_ctl_rx_flit_bank
  import ucie_ctl_rx_pkg::*;
#(
  parameter int NBYTES = DEF_NBYTES,
  parameter int BEATS  = DEF_BEATS,
  parameter int CW     = $clog2(DEF_BEATS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [CW-1:0]            i_wr_slot,
  input  logic [NBYTES-1:0]        i_wr_data,
  input  logic                     i_set_full,
  input  logic                     i_clr_full,
  output logic [NBYTES*BEATS-1:0]  o_data,
  output logic                     o_full
);

  logic [NBYTES*BEATS-1:0] r_data;
  logic                    r_full;

  // Bank storage and full flag; a set and a clear never target the same
  // bank in one cycle, but set is given priority for robustness.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_data[int'(i_wr_slot)*NBYTES +: NBYTES] <= i_wr_data;
      end
      if (i_set_full) begin
        r_full <= 1'b1;
      end else if (i_clr_full) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule : ucie_ctl_rx_flit_bank

// File: rtl/ucie_ctl_rx_flit_assembler.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_flit_assembler
// Packs BEATS consecutive RX-buffer beats into one flit and presents it to
// the protocol layer over valid/ready. Two ping-pong banks let a new flit
// fill while the previous one waits for ready.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-low reset
//   i_en               enable; dropping it discards a partial flit
//   i_beat_data/valid  beat stream (no backpressure)
//   o_flit_data/valid  assembled flit, beat 0 in the LSBs
//   i_flit_ready       consumer accepts the flit
//   o_beat_cnt         beats collected in the flit currently filling
//   o_partial_flush    one-cycle pulse when a partial flit is discarded
//   o_overflow         sticky: a beat was dropped, both banks full
// ---------------------------------------------------------------------------
module ucie_ctl_rx_flit_assembler
  import ucie_ctl_rx_pkg::*;
#(
  parameter int NBYTES = DEF_NBYTES,
  parameter int BEATS  = DEF_BEATS
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [NBYTES-1:0]          i_beat_data,
  input  logic                       i_beat_valid,
  output logic [NBYTES*BEATS-1:0]    o_flit_data,
  output logic                       o_flit_valid,
  input  logic                       i_flit_ready,
  output logic [$clog2(BEATS)-1:0]   o_beat_cnt,
  output logic                       o_partial_flush,
  output logic                       o_overflow
);

  localparam int L_FLIT_W = NBYTES * BEATS;
  localparam int L_CNT_W  = $clog2(BEATS);
  localparam logic [L_CNT_W-1:0] L_LAST = L_CNT_W'(BEATS - 1);

  fill_state_e          r_state;
  fill_state_e          w_state_nxt;
  logic [L_CNT_W-1:0]   r_cnt;
  logic [L_CNT_W-1:0]   w_cnt_nxt;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic                 r_overflow;
  logic                 r_flush;

  logic                 w_full      [2];
  logic [L_FLIT_W-1:0]  w_bank_data [2];

  logic w_pop;
  logic w_bank_free;
  logic w_accept;
  logic w_last;
  logic w_drop;
  logic w_flush;

  // A full write bank can only be the oldest flit (wr_ptr == rd_ptr); if it
  // is popped this cycle the bank is treated as free so the release wins and
  // the beat lands as slot 0 at the same edge the flit leaves.
  assign w_pop       = w_full[r_rd_ptr] & i_flit_ready;
  assign w_bank_free = ~w_full[r_wr_ptr] | (w_pop & (r_wr_ptr == r_rd_ptr));
  assign w_accept    = i_en & i_beat_valid & w_bank_free;
  assign w_last      = w_accept & (r_cnt == L_LAST);
  assign w_drop      = i_en & i_beat_valid & ~w_bank_free;
  assign w_flush     = ~i_en & (r_cnt != {L_CNT_W{1'b0}});

  // Fill state machine next-state and next beat count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = L_CNT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_flush || w_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {L_CNT_W{1'b0}};
        end else if (w_accept) begin
          w_cnt_nxt   = r_cnt + L_CNT_W'(1);
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {L_CNT_W{1'b0}};
      end
    endcase
  end

  // State, pointers, sticky overflow and flush pulse registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {L_CNT_W{1'b0}};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_overflow <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flush <= w_flush;
      if (w_last) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    ucie_ctl_rx_flit_bank #(
      .NBYTES (NBYTES),
      .BEATS  (BEATS),
      .CW     (L_CNT_W)
    ) u_bank (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_en    (w_accept & (r_wr_ptr == 1'(g))),
      .i_wr_slot  (r_cnt),
      .i_wr_data  (i_beat_data),
      .i_set_full (w_last & (r_wr_ptr == 1'(g))),
      .i_clr_full (w_pop & (r_rd_ptr == 1'(g))),
      .o_data     (w_bank_data[g]),
      .o_full     (w_full[g])
    );
  end

  assign o_flit_valid    = w_full[r_rd_ptr];
  assign o_flit_data     = w_bank_data[r_rd_ptr];
  assign o_beat_cnt      = r_cnt;
  assign o_partial_flush = r_flush;
  assign o_overflow      = r_overflow;

endmodule : ucie_ctl_rx_flit_assembler
